zc_period_avg: RTL and testbench
================================

ZC_PERIOD_AVG -- requirements
Module: zc_period_avg

Interface
REQ-001 Parameter: WIDTH, 16, sample width of the input stream.
REQ-002 Parameter: COUNTER_SIZE, 32, width of the interval counter and of the output period word.
REQ-003 Parameter: LOG2_AVG_MAX, 4, maximum log2 of the number of intervals averaged.
REQ-004 Port: clk, input, 1, sole clock; all logic is on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high reset.
REQ-006 Port: clear, input, 1, synchronous soft clear.
REQ-007 Port: log2_navg, input, $clog2(LOG2_AVG_MAX+1), log2 of the number of intervals averaged per result.
REQ-008 Port: num_count, output, 32, crossings accepted since reset or clear.
REQ-009 Port: drop_count, output, 32, results discarded because the output register was full.
REQ-010 Port: i_tdata, input, WIDTH, sample; pass-through only, not used arithmetically.
REQ-011 Port: i_zc, input, 1, crossing flag, qualified by i_tvalid.
REQ-012 Port: i_tvalid / i_tlast / i_tready, input / input / output, 1 each, upstream AXI-stream handshake.
REQ-013 Port: o_tdata, output, COUNTER_SIZE, averaged period in samples.
REQ-014 Port: o_tvalid / o_tlast / o_tready, output / output / input, 1 each, downstream AXI-stream handshake.

Function
REQ-015 A beat is accepted when i_tvalid && i_tready; i_tready SHALL be 1 whenever reset is deasserted.
REQ-016 State machine states:
- IDLE: waiting for the first crossing.
- MEASURE: counting intervals.
REQ-017 IDLE->MEASURE on an accepted beat with i_zc=1; the interval counter loads 0 and the accumulator and interval index load 0.
REQ-018 In MEASURE, each accepted beat increments the interval counter; the counter saturates at 2^COUNTER_SIZE-1.
REQ-019 Interval length is the number of accepted beats after one crossing beat up to and including the next crossing beat; crossings on consecutive beats give interval 1.
REQ-020 On an accepted crossing beat in MEASURE:
- the completed interval is added to the accumulator (width COUNTER_SIZE+LOG2_AVG_MAX, no overflow possible);
- the interval counter restarts at 0;
- the interval index increments.
REQ-021 When the index reaches 2^log2_navg, the result is computed as accumulator >> log2_navg, truncated and then saturated to COUNTER_SIZE bits. The accumulator and index then reset and the FSM stays in MEASURE.
REQ-022 log2_navg SHALL be sampled at IDLE->MEASURE and at each window completion; mid-window changes have no effect.
REQ-023 Values of log2_navg above LOG2_AVG_MAX SHALL be clamped to LOG2_AVG_MAX.
REQ-024 Output register:
- single entry;
- the result appears with o_tvalid=1 on the cycle after the completing beat is accepted;
- o_tlast=1 on every output beat;
- o_tdata is held stable while o_tvalid=1 and o_tready=0.
REQ-025 If a new result completes while o_tvalid=1 and o_tready=0, the new result SHALL be discarded and drop_count incremented. If o_tready=1 on that same cycle, the old result is consumed, the new one is loaded, and there is no drop.
REQ-026 An accepted beat with i_tlast=1 SHALL end the burst:
- the FSM returns to IDLE and any partial window is discarded;
- if that beat also has i_zc=1, the crossing is counted in num_count and still completes its interval/window per REQ-020/REQ-021.
REQ-027 num_count increments on every accepted beat with i_zc=1; drop_count and num_count wrap modulo 2^32.
REQ-028 clear SHALL:
- return the FSM to IDLE;
- zero the counters, accumulator, num_count and drop_count;
- deassert o_tvalid.
Beats accepted in the clear cycle are ignored.

Reset
REQ-029 While reset is high, all registers take reset values asynchronously: FSM=IDLE, o_tvalid=0, o_tdata=0, o_tlast=0, i_tready=0, num_count=0, drop_count=0.
REQ-030 The first beat acceptance is allowed on the first rising edge after reset deasserts.
REQ-031 Reset mid-window SHALL discard all partial state with no output.

Verification
REQ-032 Periodic window: log2_navg=2, i_zc every 8th beat, o_tready=1 -> first o_tdata=8 one cycle after the 5th crossing, then one result every 32 beats; num_count=5 at the first result.
REQ-033 Uneven intervals: log2_navg=1, intervals 3 and 6 -> o_tdata=4 (9>>1, truncated).
REQ-034 Back-pressure: o_tready=0 across two window completions -> the first result is held, drop_count=1; at a second completion with o_tready=1 on the same cycle -> new value loaded, drop_count stays 1.
REQ-035 Burst end: i_tlast on a non-crossing beat with 2 of 4 intervals done -> no output, FSM in IDLE, and the next crossing starts a fresh window.
REQ-036 Saturation: COUNTER_SIZE=8, log2_navg=0, gap of 300 beats -> o_tdata=255.
REQ-037 Async reset asserted mid-window with o_tvalid=1 -> o_tvalid=0 immediately, counters 0, and no output until a fresh window completes.

Source files
------------

// File: rtl/zc_period_avg.sv
// Zero-crossing period averager: measures beat intervals between qualified crossings
// and emits the mean over 2^log2_navg intervals on a single-entry AXI-stream output.
module zc_period_avg #(
    parameter int WIDTH        = 16,
    parameter int COUNTER_SIZE = 32,
    parameter int LOG2_AVG_MAX = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [$clog2(LOG2_AVG_MAX+1)-1:0] log2_navg,
    output logic [31:0]                      num_count,
    output logic [31:0]                      drop_count,
    input  logic [WIDTH-1:0]                 i_tdata,
    input  logic                             i_zc,
    input  logic                             i_tvalid,
    input  logic                             i_tlast,
    output logic                             i_tready,
    output logic [COUNTER_SIZE-1:0]          o_tdata,
    output logic                             o_tvalid,
    output logic                             o_tlast,
    input  logic                             o_tready
);

    localparam int NW = $clog2(LOG2_AVG_MAX + 1);
    localparam int AW = COUNTER_SIZE + LOG2_AVG_MAX;
    localparam int IW = LOG2_AVG_MAX + 1;
    localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                  state;
    logic [COUNTER_SIZE-1:0] interval_cnt;
    logic [AW-1:0]           acc;
    logic [IW-1:0]           idx;
    logic [NW-1:0]           navg;

    logic                    accept;
    logic                    crossing;
    logic                    window_done;
    logic [NW-1:0]           navg_in;
    logic [COUNTER_SIZE-1:0] interval;
    logic [AW-1:0]           acc_sum;
    logic [AW-1:0]           acc_shift;
    logic [IW-1:0]           idx_next;
    logic [COUNTER_SIZE-1:0] result;
    logic                    unused_tdata;

    // The input never stalls; readiness only drops while reset is held.
    assign i_tready     = ~reset;
    assign unused_tdata = ^i_tdata;

    assign accept   = i_tvalid & i_tready;
    assign crossing = accept & i_zc;
    assign navg_in  = (log2_navg > NW'(LOG2_AVG_MAX)) ? NW'(LOG2_AVG_MAX) : log2_navg;

    // The interval ending on a crossing beat includes that beat, hence the +1.
    assign interval    = (interval_cnt == CNT_MAX) ? CNT_MAX : interval_cnt + 1'b1;
    assign acc_sum     = acc + AW'(interval);
    assign idx_next    = idx + 1'b1;
    assign window_done = crossing && (state == MEASURE) && (idx_next == (IW'(1) << navg));
    assign acc_shift   = acc_sum >> navg;
    assign result      = ((acc_shift >> COUNTER_SIZE) != '0) ? CNT_MAX
                                                             : acc_shift[COUNTER_SIZE-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            interval_cnt <= '0;
            acc          <= '0;
            idx          <= '0;
            navg         <= '0;
            num_count    <= '0;
            drop_count   <= '0;
            o_tdata      <= '0;
            o_tvalid     <= 1'b0;
            o_tlast      <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            interval_cnt <= '0;
            acc          <= '0;
            idx          <= '0;
            navg         <= '0;
            num_count    <= '0;
            drop_count   <= '0;
            o_tdata      <= '0;
            o_tvalid     <= 1'b0;
            o_tlast      <= 1'b0;
        end else begin
            if (crossing) begin
                num_count <= num_count + 32'd1;
            end

            case (state)
                IDLE: begin
                    // A crossing that also ends the burst has nothing to measure.
                    if (crossing && !i_tlast) begin
                        state        <= MEASURE;
                        interval_cnt <= '0;
                        acc          <= '0;
                        idx          <= '0;
                        navg         <= navg_in;
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        if (i_zc) begin
                            interval_cnt <= '0;
                            if (window_done) begin
                                acc  <= '0;
                                idx  <= '0;
                                navg <= navg_in;
                            end else begin
                                acc <= acc_sum;
                                idx <= idx_next;
                            end
                        end else begin
                            interval_cnt <= interval;
                        end
                        if (i_tlast) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase

            // A finished window replaces the held result only if it is being consumed.
            if (window_done) begin
                if (!o_tvalid || o_tready) begin
                    o_tdata  <= result;
                    o_tvalid <= 1'b1;
                    o_tlast  <= 1'b1;
                end else begin
                    drop_count <= drop_count + 32'd1;
                end
            end else if (o_tvalid && o_tready) begin
                o_tvalid <= 1'b0;
                o_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zc_period_avg.sv
// Testbench for zc_period_avg: directed vector table, hand-written corner sequences
// and randomized traffic compared against an interval-list reference model.
module tb_zc_period_avg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [2:0]  log2_navg = '0;
    logic [31:0] num_count, drop_count;
    logic [15:0] i_tdata = '0;
    logic        i_zc = 1'b0, i_tvalid = 1'b0, i_tlast = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tvalid, o_tlast;
    logic        o_tready = 1'b0;

    logic [31:0] num_count8, drop_count8;
    logic        i_tready8;
    logic [7:0]  o_tdata8;
    logic        o_tvalid8, o_tlast8;

    zc_period_avg dut (
        .clk(clk), .reset(reset), .clear(clear), .log2_navg(log2_navg),
        .num_count(num_count), .drop_count(drop_count),
        .i_tdata(i_tdata), .i_zc(i_zc), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
        .o_tlast(o_tlast), .o_tready(o_tready)
    );

    zc_period_avg #(.COUNTER_SIZE(8)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .log2_navg(log2_navg),
        .num_count(num_count8), .drop_count(drop_count8),
        .i_tdata(i_tdata), .i_zc(i_zc), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
        .i_tready(i_tready8), .o_tdata(o_tdata8), .o_tvalid(o_tvalid8),
        .o_tlast(o_tlast8), .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: keeps the list of completed intervals of the current window.
    int unsigned       m_num, m_drop;
    bit                m_valid, m_active;
    longint unsigned   m_data, m_gap;
    int                m_n;
    longint unsigned   intervals[$];

    function automatic int clampNavg(input logic [2:0] n);
        return (n > 3'd4) ? 4 : int'(n);
    endfunction

    task automatic modelReset();
        m_num = 0; m_drop = 0; m_valid = 0; m_data = 0;
        m_active = 0; m_gap = 0; m_n = 0;
        intervals.delete();
    endtask

    task automatic modelEdge(input logic vld, zc, last, clr, rdy, input logic [2:0] navg);
        bit consumed;
        bit newres;
        longint unsigned res, sum;
        consumed = m_valid && rdy;
        newres = 0;
        res = 0;
        if (clr) begin
            modelReset();
        end else begin
            if (vld) begin
                if (zc) m_num++;
                if (!m_active) begin
                    if (zc && !last) begin
                        m_active = 1; m_gap = 0; intervals.delete(); m_n = clampNavg(navg);
                    end
                end else begin
                    m_gap++;
                    if (zc) begin
                        intervals.push_back(m_gap);
                        m_gap = 0;
                        if (intervals.size() == (1 << m_n)) begin
                            sum = 0;
                            foreach (intervals[k]) sum += intervals[k];
                            res = sum >> m_n;
                            if (res > 64'hFFFF_FFFF) res = 64'hFFFF_FFFF;
                            newres = 1;
                            intervals.delete();
                            m_n = clampNavg(navg);
                        end
                    end
                    if (last) m_active = 0;
                end
            end
            if (newres) begin
                if (!m_valid || rdy) begin
                    m_valid = 1; m_data = res;
                end else begin
                    m_drop++;
                end
            end else if (consumed) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic vld, zc, last, clr, rdy, input logic [2:0] navg);
        i_tvalid = vld; i_zc = zc; i_tlast = last; clear = clr;
        o_tready = rdy; log2_navg = navg; i_tdata = 16'($urandom);
        @(posedge clk);
        modelEdge(vld, zc, last, clr, rdy, navg);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, " o_tvalid"}, o_tvalid, m_valid);
        check({tag, " o_tlast"}, o_tlast, m_valid);
        if (m_valid) check({tag, " o_tdata"}, o_tdata, m_data);
        check({tag, " num_count"}, num_count, m_num);
        check({tag, " drop_count"}, drop_count, m_drop);
        check({tag, " i_tready"}, i_tready, 1);
    endtask

    logic [2:0] cur_navg = '0;

    task automatic stepBeat(input logic zc, last, rdy, input string tag);
        applyStimulus(1'b1, zc, last, 1'b0, rdy, cur_navg);
        checkOutput(tag);
    endtask

    task automatic doClear();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cur_navg);
        checkOutput("clear");
    endtask

    typedef struct {
        logic        zc;
        logic        last;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_num;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Intervals 3 and 6 averaged over two: (3+6)>>1 = 4
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd2};
        for (int i = 4; i <= 8; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd4, 32'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd4, 32'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd3};

        modelReset();
        repeat (3) @(negedge clk);
        check("reset o_tvalid", o_tvalid, 0);
        check("reset o_tdata", o_tdata, 0);
        check("reset o_tlast", o_tlast, 0);
        check("reset i_tready", i_tready, 0);
        check("reset num_count", num_count, 0);
        check("reset drop_count", drop_count, 0);
        reset = 1'b0;
        #1;
        check("post-reset i_tready", i_tready, 1);

        cur_navg = 3'd1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].zc, vecs[i].last, 1'b0, vecs[i].rdy, cur_navg);
            check($sformatf("vec%0d o_tvalid", i), o_tvalid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("vec%0d o_tdata", i), o_tdata, vecs[i].exp_data);
            check($sformatf("vec%0d num_count", i), num_count, vecs[i].exp_num);
            checkOutput("vec model");
        end

        // Periodic crossings every 8 beats, windows of 4 intervals
        cur_navg = 3'd2;
        doClear();
        for (int b = 0; b <= 64; b++) begin
            stepBeat(b % 8 == 0, 1'b0, 1'b1, "periodic");
            if (b == 31) check("periodic early valid", o_tvalid, 0);
            if (b == 32) begin
                check("periodic first valid", o_tvalid, 1);
                check("periodic first data", o_tdata, 8);
                check("periodic first num", num_count, 5);
            end
            if (b == 33) check("periodic consumed", o_tvalid, 0);
            if (b == 64) begin
                check("periodic second data", o_tdata, 8);
                check("periodic second num", num_count, 9);
            end
        end

        // Back-pressure: second result dropped, third replaces the consumed first
        cur_navg = 3'd0;
        doClear();
        for (int b = 0; b <= 15; b++) begin
            stepBeat(b == 0 || b == 4 || b == 10 || b == 15, 1'b0, b == 15, "backpressure");
            if (b == 4) begin
                check("bp first data", o_tdata, 4);
                check("bp first drop", drop_count, 0);
            end
            if (b == 10) begin
                check("bp held valid", o_tvalid, 1);
                check("bp held data", o_tdata, 4);
                check("bp drop", drop_count, 1);
            end
            if (b == 15) begin
                check("bp reload data", o_tdata, 5);
                check("bp reload drop", drop_count, 1);
            end
        end

        // Burst end mid-window discards the partial window
        cur_navg = 3'd2;
        doClear();
        for (int b = 0; b <= 20; b++) begin
            stepBeat(b inside {0, 2, 4, 8, 11, 14, 17, 20}, b == 5, 1'b1, "burst");
            if (b == 11 || b == 19) check($sformatf("burst no output b%0d", b), o_tvalid, 0);
            if (b == 20) begin
                check("burst fresh valid", o_tvalid, 1);
                check("burst fresh data", o_tdata, 3);
            end
        end

        // Interval saturation on the 8-bit instance
        cur_navg = 3'd0;
        doClear();
        for (int b = 0; b <= 300; b++) stepBeat(b == 0 || b == 300, 1'b0, 1'b1, "saturate");
        check("sat8 valid", o_tvalid8, 1);
        check("sat8 data", o_tdata8, 255);
        check("sat32 data", o_tdata, 300);

        // Asynchronous reset mid-window with a result pending
        doClear();
        for (int b = 0; b <= 4; b++) stepBeat(b == 0 || b == 3, 1'b0, 1'b0, "prereset");
        check("prereset valid", o_tvalid, 1);
        #2 reset = 1'b1;
        #1;
        check("async reset o_tvalid", o_tvalid, 0);
        check("async reset o_tlast", o_tlast, 0);
        check("async reset num_count", num_count, 0);
        check("async reset drop_count", drop_count, 0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        stepBeat(1'b0, 1'b0, 1'b0, "postreset");
        stepBeat(1'b1, 1'b0, 1'b0, "postreset");
        check("postreset first crossing no output", o_tvalid, 0);
        stepBeat(1'b0, 1'b0, 1'b0, "postreset");
        stepBeat(1'b1, 1'b0, 1'b0, "postreset");
        check("postreset fresh valid", o_tvalid, 1);
        check("postreset fresh data", o_tdata, 2);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                          $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
            checkOutput("random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
